// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, execute-unit FSM encoding, default width.
// The ALU control decoder uses this package too.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_e;

  // True for the three serial shift ops.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU ops plus illegal-op detection. Shift and MUL codes are
// legal here but produce 0; the execute unit iterates those itself.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  // Result mux over the single-cycle ops; unknown codes flag illegal.
  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR: res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: res = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle ops in one pass, shifts at
// one bit per cycle, MUL as shift-add at one multiplier bit per cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  // cnt must hold WIDTH itself for MUL, hence one extra bit over SHW.
  localparam int CW = SHW + 1;

  alu_state_e       state, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] mcand, mcand_d;
  logic [WIDTH-1:0] mplier, mplier_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] res_d;
  logic             zero_d, ill_d;

  logic [WIDTH-1:0] comb_res;
  logic             comb_ill;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mul_sum;
  logic [SHW-1:0]   shamt;

  alu_comb_ops #(.WIDTH(WIDTH)) u_comb (
    .op      (operation),
    .a       (src_a),
    .b       (src_b),
    .res     (comb_res),
    .illegal (comb_ill)
  );

  assign shamt     = src_b[SHW-1:0];
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // One-bit step of the latched shift op and one shift-add step of MUL.
  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc[WIDTH-1:1]};
      default: shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
    mul_sum = acc + (mplier[0] ? mcand : '0);
  end

  // Next-state and datapath updates; output regs load only when entering DONE.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    acc_d    = acc;
    mcand_d  = mcand;
    mplier_d = mplier;
    cnt_d    = cnt;
    res_d    = result;
    zero_d   = zero;
    ill_d    = illegal_op;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = operation;
          if (is_shift_op(operation)) begin
            if (shamt == '0) begin
              res_d   = src_a;
              zero_d  = (src_a == '0);
              ill_d   = 1'b0;
              state_d = ST_DONE;
            end else begin
              acc_d   = src_a;
              cnt_d   = {1'b0, shamt};
              state_d = ST_SHIFT;
            end
          end else if (operation == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = src_a;
            mplier_d = src_b;
            cnt_d    = CW'(WIDTH);
            state_d  = ST_MUL;
          end else begin
            res_d   = comb_res;
            zero_d  = (comb_res == '0);
            ill_d   = comb_ill;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          res_d   = shifted;
          zero_d  = (shifted == '0);
          ill_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          res_d   = mul_sum;
          zero_d  = (mul_sum == '0);
          ill_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      result     <= '0;
      zero       <= 1'b1;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      acc        <= acc_d;
      mcand      <= mcand_d;
      mplier     <= mplier_d;
      cnt        <= cnt_d;
      result     <= res_d;
      zero       <= zero_d;
      illegal_op <= ill_d;
    end
  end

endmodule
